len_to_mask_seq: RTL and testbench

- Streaming successor to the combinational length-to-thermometer converter.
- Accepts a packet length in bytes over a valid/ready handshake and emits one BEAT_W-bit byte-enable mask per beat, with a last flag.
- Full beats carry all-ones masks; the tail beat carries a thermometer mask of the residual byte count.
- Sits between a header parser and a data-path keep/strobe generator.

---
 rtl/len_to_mask_seq_pkg.sv | 16 +
 rtl/len_to_mask_seq_thermo.sv | 19 +
 rtl/len_to_mask_seq.sv | 110 +++++++++++
 tb/tb_len_to_mask_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/len_to_mask_seq_pkg.sv
// Shared types and helpers for the streaming length-to-byte-enable sequencer.
package len_to_mask_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int beat_clog2(input int v);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= v) return r;
    end
    return 31;
  endfunction

endpackage

// File: rtl/len_to_mask_seq_thermo.sv
// Combinational thermometer: bit i set when the residual byte count exceeds i.
module thermo_mask
  import len_to_mask_seq_pkg::*;
#(
  parameter int BEAT_W = 8,
  parameter int CNT_W  = beat_clog2(BEAT_W) + 1
) (
  input  logic [CNT_W-1:0]  cnt,
  output logic [BEAT_W-1:0] mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < BEAT_W; i++) begin
      mask[i] = (cnt > CNT_W'(i));
    end
  end

endmodule

// File: rtl/len_to_mask_seq.sv
// Streams one byte-enable mask per beat for an accepted packet length.
// Build option LEN_TO_MASK_SEQ_MSB_FIRST_EN bit-reverses every mask for big-endian lanes.
module len_to_mask_seq
  import len_to_mask_seq_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              len_valid_i,
  output logic              len_ready_o,
  input  logic [LEN_W-1:0]  len_i,
  output logic              mask_valid_o,
  input  logic              mask_ready_i,
  output logic [BEAT_W-1:0] mask_o,
  output logic              last_o
);

  localparam int              CNT_W    = beat_clog2(BEAT_W) + 1;
  localparam logic [LEN_W-1:0] BEAT_LEN = LEN_W'(BEAT_W);

  state_t             state;
  logic [LEN_W-1:0]   remaining;
  logic [LEN_W-1:0]   next_rem;
  logic [CNT_W-1:0]   next_cnt;
  logic [BEAT_W-1:0]  thermo;
  logic [BEAT_W-1:0]  next_mask;
  logic               accept;
  logic               xfer;

  assign xfer        = mask_valid_o & mask_ready_i;
  assign len_ready_o = (state == IDLE) | (xfer & last_o);
  assign accept      = len_valid_i & len_ready_o;

  // The next beat is built from either the fresh length or what is left after this beat.
  assign next_rem = accept ? len_i : (remaining - BEAT_LEN);
  assign next_cnt = (next_rem > BEAT_LEN) ? CNT_W'(BEAT_W) : next_rem[CNT_W-1:0];

  thermo_mask #(
    .BEAT_W (BEAT_W),
    .CNT_W  (CNT_W)
  ) u_thermo (
    .cnt  (next_cnt),
    .mask (thermo)
  );

`ifdef LEN_TO_MASK_SEQ_MSB_FIRST_EN
  always_comb begin
    next_mask = '0;
    for (int i = 0; i < BEAT_W; i++) begin
      next_mask[BEAT_W-1-i] = thermo[i];
    end
  end
`else
  assign next_mask = thermo;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mask_valid_o <= 1'b0;
      mask_o       <= '0;
      last_o       <= 1'b0;
      remaining    <= '0;
    end else if (accept || (xfer && !last_o)) begin
      state        <= BUSY;
      mask_valid_o <= 1'b1;
      mask_o       <= next_mask;
      last_o       <= (next_rem <= BEAT_LEN);
      remaining    <= next_rem;
    end else if (xfer) begin
      state        <= IDLE;
      mask_valid_o <= 1'b0;
      mask_o       <= '0;
      last_o       <= 1'b0;
      remaining    <= '0;
    end
  end

`ifdef FORMAL
  logic [LEN_W:0] f_len;
  logic [LEN_W:0] f_sum;
  logic [LEN_W:0] f_pop;

  assign f_pop = (LEN_W + 1)'($countones(mask_o));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_len <= '0;
      f_sum <= '0;
    end else if (accept) begin
      f_len <= {1'b0, len_i};
      f_sum <= '0;
    end else if (xfer) begin
      f_sum <= f_sum + f_pop;
    end
  end

  always @(posedge clk) begin
    if (!rst && mask_valid_o) begin
      assert ($onehot({1'b0, mask_o} + {{BEAT_W{1'b0}}, 1'b1}));
    end
    if (!rst && xfer && last_o) begin
      assert (f_sum + f_pop == f_len);
    end
  end
`endif

endmodule

// File: tb/tb_len_to_mask_seq.sv
// Scoreboard bench for len_to_mask_seq with directed packet lengths (BEAT_W = 8).
module tb_len_to_mask_seq;

  localparam int LEN_W  = 16;
  localparam int BEAT_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              len_valid_i = 1'b0;
  logic              len_ready_o;
  logic [LEN_W-1:0]  len_i = '0;
  logic              mask_valid_o;
  logic              mask_ready_i = 1'b1;
  logic [BEAT_W-1:0] mask_o;
  logic              last_o;

  len_to_mask_seq #(.LEN_W(LEN_W), .BEAT_W(BEAT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .len_valid_i  (len_valid_i),
    .len_ready_o  (len_ready_o),
    .len_i        (len_i),
    .mask_valid_o (mask_valid_o),
    .mask_ready_i (mask_ready_i),
    .mask_o       (mask_o),
    .last_o       (last_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];
  int xfer_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Hand-written tail masks are LSB-first; the big-endian build expects them mirrored.
  function automatic logic [7:0] tail(input logic [7:0] lsb_first);
    logic [7:0] r;
`ifdef LEN_TO_MASK_SEQ_MSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[7-i] = lsb_first[i];
`else
    r = lsb_first;
`endif
    return r;
  endfunction

  task automatic push(input logic [7:0] m, input logic l);
    exp_q.push_back({l, m});
  endtask

  // Call just after a posedge; returns #1 after the accepting edge.
  task automatic offer(input int len);
    bit ok = 0;
    len_valid_i = 1'b1;
    len_i = LEN_W'(len);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (len_ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    len_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk({name, "_drain"}, 32'(ok), 1);
    @(negedge clk);
    chk({name, "_valid_drop"}, 32'(mask_valid_o), 0);
    chk({name, "_ready_idle"}, 32'(len_ready_o), 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every transfer and checks hold stability during stalls.
  initial begin
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat = '0;
    logic [8:0] exp_beat;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_stable", 32'({last_o, mask_o}), 32'(prev_beat));
          chk("hold_valid", 32'(mask_valid_o), 1);
        end
        if (mask_valid_o && mask_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'({last_o, mask_o}), 32'h1ff);
          end else begin
            exp_beat = exp_q.pop_front();
            chk("beat", 32'({last_o, mask_o}), 32'(exp_beat));
          end
          if (last_o) chk("ready_on_last", 32'(len_ready_o), 1);
          xfer_cyc.push_back(cyc);
        end
        prev_stall = mask_valid_o && !mask_ready_i;
        prev_beat  = {last_o, mask_o};
      end
    end
  end

  initial begin
    int base;
    // Reset values
    @(negedge clk);
    chk("rst_valid", 32'(mask_valid_o), 0);
    chk("rst_mask", 32'(mask_o), 0);
    chk("rst_last", 32'(last_o), 0);
    chk("rst_ready", 32'(len_ready_o), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // len=19: FF, FF, tail 07; first beat one cycle after accept
    push(8'hff, 0); push(8'hff, 0); push(tail(8'h07), 1);
    offer(19);
    @(negedge clk);
    chk("latency_valid", 32'(mask_valid_o), 1);
    wait_idle("len19");

    push(8'hff, 0); push(8'hff, 1);
    offer(16);
    wait_idle("len16");

    push(8'hff, 1);
    offer(8);
    wait_idle("len8");

    push(8'h00, 1);
    offer(0);
    wait_idle("len0");

    // len=11 with downstream stalls on both beats
    mask_ready_i = 1'b0;
    push(8'hff, 0); push(tail(8'h07), 1);
    offer(11);
    repeat (3) @(posedge clk);
    #1;
    mask_ready_i = 1'b1;
    @(posedge clk);
    #1;
    mask_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mask_ready_i = 1'b1;
    wait_idle("len11_stall");

    // Back-to-back len=5 then len=9 with no bubble
    base = xfer_cyc.size();
    push(tail(8'h1f), 1); push(8'hff, 0); push(tail(8'h01), 1);
    offer(5);
    offer(9);
    wait_idle("b2b");
    if (xfer_cyc.size() == base + 3) begin
      chk("b2b_gap0", 32'(xfer_cyc[base+1] - xfer_cyc[base]), 1);
      chk("b2b_gap1", 32'(xfer_cyc[base+2] - xfer_cyc[base+1]), 1);
    end else begin
      chk("b2b_count", 32'(xfer_cyc.size() - base), 3);
    end

    // Reset during the second beat of len=40 drops the packet
    push(8'hff, 0); push(8'hff, 0); push(8'hff, 0); push(8'hff, 0); push(8'hff, 1);
    offer(40);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_valid", 32'(mask_valid_o), 0);
    chk("midrst_ready", 32'(len_ready_o), 1);
    chk("midrst_last", 32'(last_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(tail(8'h07), 1);
    offer(3);
    wait_idle("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
